// File: rtl/gpu_pkg.sv
// Shared GPU definitions: coordinate/colour widths, the arbiter state
// encoding, default visible-area size and the pixel write record.
package gpu_pkg;

    localparam int COORD_W      = 10;
    localparam int COLOR_W      = 12;
    localparam int GID_W        = 3;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_wr_t;

    // True when the pixel lies inside the visible area given by the limits.
    function automatic logic pixel_in_bounds(input pixel_wr_t p,
                                             input logic [COORD_W:0] h_lim,
                                             input logic [COORD_W:0] v_lim);
        return ({1'b0, p.x} < h_lim) && ({1'b0, p.y} < v_lim);
    endfunction

endpackage

// File: rtl/pixel_write_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester at or after the
// pointer, wrapping modulo NUM_REQ. The pointer is always below NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [2:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [2:0]         o_grant_idx,
    output logic               o_any_valid
);

    logic [7:0] valid_ext_s;
    logic [3:0] idx_s;

    assign valid_ext_s = 8'(i_valid);

    // Walk the requesters starting at the pointer and keep the first hit.
    always_comb begin
        o_grant_idx = 3'd0;
        o_any_valid = 1'b0;
        idx_s       = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = {1'b0, i_ptr} + 4'(i);
            if (idx_s >= 4'(NUM_REQ)) begin
                idx_s = idx_s - 4'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!o_any_valid && valid_ext_s[idx_s[2:0]]) begin
                o_any_valid = 1'b1;
                o_grant_idx = idx_s[2:0];
            end else begin
                o_any_valid = o_any_valid;
            end
        end
    end

    // Expand the winning index into a one-hot grant vector.
    always_comb begin
        o_grant_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_grant_oh[k] = o_any_valid && (o_grant_idx == 3'(k));
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing the framebuffer pixel-write port between
// NUM_REQ sources. One request is accepted per IDLE cycle, latched, and
// presented downstream until i_wr_ready. Optional feature macro:
// PIXEL_BOUNDS_CHECK_EN drops (and counts) writes outside the visible area.
module pixel_write_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic [NUM_REQ*10-1:0]  i_req_x,
    input  logic [NUM_REQ*10-1:0]  i_req_y,
    input  logic [NUM_REQ*12-1:0]  i_req_color,
    output logic                   o_wr_valid,
    input  logic                   i_wr_ready,
    output logic [9:0]             o_pixel_x,
    output logic [9:0]             o_pixel_y,
    output logic [11:0]            o_color,
    output logic [2:0]             o_grant_id,
    output logic                   o_busy,
    output logic [15:0]            o_drop_count
);

    localparam logic [COORD_W:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [COORD_W:0] V_LIM = 11'(V_ACTIVE);
`ifdef PIXEL_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    arb_state_e         state_q, state_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic               wr_valid_q, wr_valid_d;
    logic               busy_q, busy_d;
    pixel_wr_t          pix_q, pix_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [15:0]        drop_count_q, drop_count_d;

    logic [NUM_REQ-1:0] grant_oh_s;
    logic [2:0]         grant_idx_s;
    logic               any_valid_s;
    logic               accept_s;
    logic               drop_s;
    logic [2:0]         ptr_next_s;
    pixel_wr_t          sel_s;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .i_valid     (i_req_valid),
        .i_ptr       (rr_ptr_q),
        .o_grant_oh  (grant_oh_s),
        .o_grant_idx (grant_idx_s),
        .o_any_valid (any_valid_s)
    );

    // Select the granted requester's packed coordinates and colour.
    always_comb begin
        sel_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx_s == 3'(k)) begin
                sel_s.x     = i_req_x[10*k +: 10];
                sel_s.y     = i_req_y[10*k +: 10];
                sel_s.color = i_req_color[12*k +: 12];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    assign o_req_ready = ((state_q == IDLE) && i_reset_n) ? grant_oh_s : '0;
    assign accept_s    = (state_q == IDLE) && any_valid_s;
    assign drop_s      = BOUNDS_EN && !pixel_in_bounds(sel_s, H_LIM, V_LIM);
    assign ptr_next_s  = (grant_idx_s == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx_s + 3'd1;

    // Next-state and next-output logic for the IDLE/ISSUE handshake.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        wr_valid_d   = wr_valid_q;
        busy_d       = busy_q;
        pix_d        = pix_q;
        grant_id_d   = grant_id_q;
        drop_count_d = drop_count_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    rr_ptr_d = ptr_next_s;
                    if (drop_s) begin
                        drop_count_d = (drop_count_q == 16'hFFFF) ? 16'hFFFF
                                                                  : drop_count_q + 16'd1;
                    end else begin
                        state_d    = ISSUE;
                        wr_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        pix_d      = sel_s;
                        grant_id_d = grant_idx_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (i_wr_ready) begin
                    state_d    = IDLE;
                    wr_valid_d = 1'b0;
                    busy_d     = 1'b0;
                end else begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d    = IDLE;
                wr_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 3'd0;
            wr_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            pix_q        <= '0;
            grant_id_q   <= 3'd0;
            drop_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_valid_q   <= wr_valid_d;
            busy_q       <= busy_d;
            pix_q        <= pix_d;
            grant_id_q   <= grant_id_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign o_wr_valid   = wr_valid_q;
    assign o_busy       = busy_q;
    assign o_pixel_x    = pix_q.x;
    assign o_pixel_y    = pix_q.y;
    assign o_color      = pix_q.color;
    assign o_grant_id   = grant_id_q;
    assign o_drop_count = drop_count_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter with three requesters: directed scenarios
// with literal expectations plus randomized traffic against a behavioural
// model. Honours PIXEL_BOUNDS_CHECK_EN when defined.
module tb_pixel_write_arbiter;

    localparam int N = 3;
`ifdef PIXEL_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*10-1:0] req_x;
    logic [N*10-1:0] req_y;
    logic [N*12-1:0] req_color;
    logic            wr_valid;
    logic            wr_ready;
    logic [9:0]      pixel_x;
    logic [9:0]      pixel_y;
    logic [11:0]     color;
    logic [2:0]      grant_id;
    logic            busy;
    logic [15:0]     drop_count;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // model state
    bit         m_busy  = 1'b0;
    int         m_ptr   = 0;
    int         m_x     = 0;
    int         m_y     = 0;
    int         m_c     = 0;
    int         m_gid   = 0;
    int         m_drops = 0;

    pixel_write_arbiter #(.NUM_REQ(N), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_x      (req_x),
        .i_req_y      (req_y),
        .i_req_color  (req_color),
        .o_wr_valid   (wr_valid),
        .i_wr_ready   (wr_ready),
        .o_pixel_x    (pixel_x),
        .o_pixel_y    (pixel_y),
        .o_color      (color),
        .o_grant_id   (grant_id),
        .o_busy       (busy),
        .o_drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // first valid requester from p upward, modulo N; -1 when none
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (p + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // model: advance on each clock edge using the inputs present at the edge
    always @(posedge clk) begin
        int g;
        int xx;
        int yy;
        if (!rst_n) begin
            m_busy = 1'b0; m_ptr = 0; m_x = 0; m_y = 0; m_c = 0; m_gid = 0; m_drops = 0;
        end else if (m_busy) begin
            if (wr_ready) m_busy = 1'b0;
        end else begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                xx = int'(req_x[10*g +: 10]);
                yy = int'(req_y[10*g +: 10]);
                if (BOUNDS && (xx >= 640 || yy >= 480)) begin
                    if (m_drops < 65535) m_drops++;
                end else begin
                    m_busy = 1'b1;
                    m_x    = xx;
                    m_y    = yy;
                    m_c    = int'(req_color[12*g +: 12]);
                    m_gid  = g;
                end
            end
        end
    end

    // compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_ready;
        #2;
        if (cmp_en) begin
            g = pick(req_valid, m_ptr);
            exp_ready = '0;
            if (!m_busy && rst_n && g >= 0) exp_ready[g] = 1'b1;
            chk("m_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("m_wr_valid", 32'(wr_valid), 32'(m_busy));
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_drop_count", 32'(drop_count), 32'(m_drops));
            if (m_busy) begin
                chk("m_pixel_x", 32'(pixel_x), 32'(m_x));
                chk("m_pixel_y", 32'(pixel_y), 32'(m_y));
                chk("m_color", 32'(color), 32'(m_c));
                chk("m_grant_id", 32'(grant_id), 32'(m_gid));
            end
        end
    end

    task automatic set_req(input int k, input int x, input int y, input int c);
        req_x[10*k +: 10]     = 10'(x);
        req_y[10*k +: 10]     = 10'(y);
        req_color[12*k +: 12] = 12'(c);
    endtask

    initial begin
        int grants[$];
        int writes;
        rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; req_color = '0; wr_ready = 1'b0;

        // reset state
        @(negedge clk); cmp_en = 1'b1;
        @(negedge clk); #1;
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pixel_x", 32'(pixel_x), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);

        // single write
        @(negedge clk); rst_n = 1'b1; req_valid = 3'b001; set_req(0, 5, 7, 12'hF00); wr_ready = 1'b1;
        #1; chk("single_ready", 32'(req_ready), 32'b001);
        @(negedge clk); req_valid = '0; #1;
        chk("single_valid", 32'(wr_valid), 32'd1);
        chk("single_x", 32'(pixel_x), 32'd5);
        chk("single_y", 32'(pixel_y), 32'd7);
        chk("single_color", 32'(color), 32'hF00);
        chk("single_gid", 32'(grant_id), 32'd0);
        @(negedge clk); #1; chk("single_done", 32'(wr_valid), 32'd0);

        // contention from a fresh pointer
        @(negedge clk); rst_n = 1'b0;
        writes = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                rst_n = 1'b1; req_valid = 3'b011;
                set_req(0, 11, 12, 12'h111); set_req(1, 21, 22, 12'h222);
            end
            #1;
            if (req_ready == 3'b001) grants.push_back(0);
            if (req_ready == 3'b010) grants.push_back(1);
            if (wr_valid && wr_ready) writes++;
        end
        req_valid = '0;
        chk("cont_writes", 32'(writes), 32'd4);
        chk("cont_ngrants", 32'(grants.size()), 32'd4);
        if (grants.size() == 4) begin
            chk("cont_g0", 32'(grants[0]), 32'd0);
            chk("cont_g1", 32'(grants[1]), 32'd1);
            chk("cont_g2", 32'(grants[2]), 32'd0);
            chk("cont_g3", 32'(grants[3]), 32'd1);
        end

        // backpressure
        @(negedge clk); req_valid = 3'b001; set_req(0, 100, 50, 12'hABC); wr_ready = 1'b0;
        #1; chk("bp_ready", 32'(req_ready), 32'b001);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); req_valid = 3'b010; set_req(0, 999, 9, 12'h000); #1;
            chk("bp_valid", 32'(wr_valid), 32'd1);
            chk("bp_x", 32'(pixel_x), 32'd100);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_ready0", 32'(req_ready), 32'd0);
        end
        @(negedge clk); req_valid = '0; wr_ready = 1'b1; #1; chk("bp_last", 32'(wr_valid), 32'd1);
        @(negedge clk); wr_ready = 1'b0; #1; chk("bp_done", 32'(wr_valid), 32'd0);

        // reset in the middle of ISSUE
        @(negedge clk); req_valid = 3'b010; set_req(1, 300, 30, 12'h333); #1;
        chk("rmid_ready", 32'(req_ready), 32'b010);
        @(negedge clk); req_valid = '0; #1; chk("rmid_issue", 32'(wr_valid), 32'd1);
        @(negedge clk); rst_n = 1'b0; req_valid = 3'b111; #1; chk("rmid_gated", 32'(req_ready), 32'd0);
        @(negedge clk); rst_n = 1'b1; wr_ready = 1'b1; #1;
        chk("rmid_valid0", 32'(wr_valid), 32'd0);
        chk("rmid_busy0", 32'(busy), 32'd0);
        chk("rmid_x0", 32'(pixel_x), 32'd0);
        chk("rmid_ptr0", 32'(req_ready), 32'b001);
        @(negedge clk); req_valid = '0; #1; chk("rmid_gid", 32'(grant_id), 32'd0);

        // pointer wrap: req2 alone, then req0+req2
        @(negedge clk); req_valid = 3'b100; set_req(2, 40, 41, 12'h444); #1;
        chk("wrap_r2", 32'(req_ready), 32'b100);
        @(negedge clk); req_valid = '0; #1; chk("wrap_gid2", 32'(grant_id), 32'd2);
        @(negedge clk); req_valid = 3'b101; set_req(0, 1, 2, 12'h555); #1;
        chk("wrap_r0", 32'(req_ready), 32'b001);
        @(negedge clk); req_valid = '0; #1; chk("wrap_gid0", 32'(grant_id), 32'd0);

        // bounds check boundary
        @(negedge clk); req_valid = 3'b001; set_req(0, 640, 0, 12'h0F0); #1;
        chk("bnd_ready", 32'(req_ready), 32'b001);
        @(negedge clk); req_valid = '0; #1;
        if (BOUNDS) begin
            chk("bnd_novalid", 32'(wr_valid), 32'd0);
            chk("bnd_drop", 32'(drop_count), 32'd1);
        end else begin
            chk("bnd_valid", 32'(wr_valid), 32'd1);
            chk("bnd_x640", 32'(pixel_x), 32'd640);
            chk("bnd_drop0", 32'(drop_count), 32'd0);
        end
        @(negedge clk); req_valid = 3'b001; set_req(0, 639, 479, 12'h0F0); #1;
        chk("bnd_ready2", 32'(req_ready), 32'b001);
        @(negedge clk); req_valid = '0; #1;
        chk("bnd_issue", 32'(wr_valid), 32'd1);
        chk("bnd_x", 32'(pixel_x), 32'd639);
        chk("bnd_y", 32'(pixel_y), 32'd479);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 199) != 0);
            req_valid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                set_req(k, int'($urandom_range(0, 700)), int'($urandom_range(0, 540)),
                        int'($urandom_range(0, 4095)));
            end
            wr_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
